// File: rtl/subtractor_pkg.sv
// subtractor_pkg
//   Shared types and constants for the sequential subtractor.
//   sub_state_e : control FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   SLICE_W     : width of the reused adder slice, in bits
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sub_state_e;

  localparam int SLICE_W = 4;

endpackage

// File: rtl/subtractor_slice4.sv
// subtractor_slice4
//   Combinational 4-bit carry-lookahead adder slice. All carries come from
//   generate/propagate terms rather than rippling through the slice.
//   Ports:
//     a_i     [3:0]  first addend
//     b_i     [3:0]  second addend
//     carry_i        carry into bit 0
//     sum_o   [3:0]  a_i + b_i + carry_i, low four bits
//     carry_o        carry out of bit 3
module subtractor_slice4
  import subtractor_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               carry_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               carry_o
);

  logic [SLICE_W-1:0] gen;
  logic [SLICE_W-1:0] prop;
  logic [SLICE_W:0]   carry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Each carry is expanded fully in terms of G/P and carry_i.
  assign carry[0] = carry_i;
  assign carry[1] = gen[0] | (prop[0] & carry_i);
  assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry_i);
  assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & carry_i);
  assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                  | (prop[3] & prop[2] & prop[1] & gen[0])
                  | (prop[3] & prop[2] & prop[1] & prop[0] & carry_i);

  assign sum_o   = prop ^ carry[SLICE_W-1:0];
  assign carry_o = carry[SLICE_W];

endmodule

// File: rtl/subtractor_seq.sv
// subtractor_seq
//   Multi-cycle WIDTH-bit subtractor: diff = a - b - borrow, computed as
//   a + ~b + ~borrow, one 4-bit slice per clock, least-significant first.
//   A single lookahead slice is reused WIDTH/4 times.
//   Ports:
//     clk_i       clock, rising edge
//     rst_ni      asynchronous active-low reset
//     valid_i     operands valid          ready_o     block can accept operands
//     a_i         minuend                 b_i         subtrahend
//     borrow_i    borrow in (subtract one more)
//     valid_o     result valid            ready_i     consumer accepts result
//     diff_o      a - b - borrow mod 2^WIDTH
//     borrow_o    unsigned borrow out (inverted final carry)
//     overflow_o  signed overflow
//     zero_o      diff_o == 0
module subtractor_seq
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("subtractor_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  sub_state_e         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   nb_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_q;
  logic               overflow_q;
  logic               zero_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_carry;
  logic               last_slice;
  logic [WIDTH-1:0]   diff_full;

  // Operands stay in place; the slice picks its nibble with an indexed select.
  assign slice_a    = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign slice_b    = nb_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign last_slice = (idx_q == IDX_W'(N - 1));

  subtractor_slice4 u_slice (
    .a_i     (slice_a),
    .b_i     (slice_b),
    .carry_i (carry_q),
    .sum_o   (slice_sum),
    .carry_o (slice_carry)
  );

  // Complete result as it will look after the final slice is written, so the
  // flags are registered from the whole word rather than a partial diff.
  always_comb begin
    diff_full = diff_q;
    diff_full[WIDTH-1 -: SLICE_W] = slice_sum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      nb_q       <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_q     <= a_i;
            nb_q    <= ~b_i;
            carry_q <= ~borrow_i;
            idx_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          diff_q[int'(idx_q)*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q <= slice_carry;
          idx_q   <= idx_q + 1'b1;
          if (last_slice) begin
            idx_q      <= '0;
            state_q    <= DONE;
            borrow_q   <= ~slice_carry;
            // Operand signs agree on the a + ~b form exactly when a and b differ in sign.
            overflow_q <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
            zero_q     <= (diff_full == '0);
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = (state_q == DONE);
  assign diff_o     = diff_q;
  assign borrow_o   = borrow_q;
  assign overflow_o = overflow_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_subtractor_seq.sv
// tb_subtractor_seq
//   Self-checking bench driving an 8-bit and a 32-bit subtractor_seq that
//   share clock and reset. Directed table vectors, hand-written stall and
//   reset-abort sequences, then randomized operations against an
//   arithmetic reference model.
module tb_subtractor_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        valid8_i, ready8_o, valid8_o, ready8_i, borrow8_i;
  logic        borrow8_o, overflow8_o, zero8_o;
  logic [7:0]  a8_i, b8_i, diff8_o;

  logic        valid32_i, ready32_o, valid32_o, ready32_i, borrow32_i;
  logic        borrow32_o, overflow32_o, zero32_o;
  logic [31:0] a32_i, b32_i, diff32_o;

  int checks   = 0;
  int failures = 0;

  subtractor_seq #(.WIDTH(8)) dut8 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .valid_i    (valid8_i),
    .ready_o    (ready8_o),
    .a_i        (a8_i),
    .b_i        (b8_i),
    .borrow_i   (borrow8_i),
    .valid_o    (valid8_o),
    .ready_i    (ready8_i),
    .diff_o     (diff8_o),
    .borrow_o   (borrow8_o),
    .overflow_o (overflow8_o),
    .zero_o     (zero8_o)
  );

  subtractor_seq #(.WIDTH(32)) dut32 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .valid_i    (valid32_i),
    .ready_o    (ready32_o),
    .a_i        (a32_i),
    .b_i        (b32_i),
    .borrow_i   (borrow32_i),
    .valid_o    (valid32_o),
    .ready_i    (ready32_i),
    .diff_o     (diff32_o),
    .borrow_o   (borrow32_o),
    .overflow_o (overflow32_o),
    .zero_o     (zero32_o)
  );

  // Handshake inputs must never be unknown once out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({valid8_i, ready8_i, valid32_i, ready32_i}))
        else $error("[TB] handshake input unknown");
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic        cur_valid(input bit wide); return wide ? valid32_o    : valid8_o;    endfunction
  function automatic logic        cur_ready(input bit wide); return wide ? ready32_o    : ready8_o;    endfunction
  function automatic logic        cur_bo   (input bit wide); return wide ? borrow32_o   : borrow8_o;   endfunction
  function automatic logic        cur_ov   (input bit wide); return wide ? overflow32_o : overflow8_o; endfunction
  function automatic logic        cur_z    (input bit wide); return wide ? zero32_o     : zero8_o;     endfunction
  function automatic logic [31:0] cur_diff (input bit wide); return wide ? diff32_o : {24'h0, diff8_o}; endfunction

  task automatic set_ready(input bit wide, input logic r);
    if (wide) ready32_i = r;
    else      ready8_i  = r;
  endtask

  // Reference: plain signed/unsigned arithmetic on 64-bit integers.
  function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic bin, output logic [31:0] d, output logic bo,
                                    output logic ov, output logic z);
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(a) & mask;
    longint ub   = longint'(b) & mask;
    longint sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    longint sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
    longint ud   = ua - ub - longint'(bin);
    longint sd   = sa - sb - longint'(bin);
    d  = 32'(ud & mask);
    bo = (ud < 0);
    ov = (sd < -half) || (sd > half - 1);
    z  = (d == 32'h0);
  endfunction

  // One full transaction: accept, wait for the result, optional stall with
  // optional ignored valid_i pokes, then the consumer handshake.
  task automatic applyStimulus(input bit wide, input logic [31:0] a, input logic [31:0] b,
                               input logic bin, input int stall, input bit poke,
                               output logic [31:0] diff, output logic bo, output logic ov,
                               output logic z, output int lat);
    if (wide) begin valid32_i = 1'b1; a32_i = a; b32_i = b; borrow32_i = bin; end
    else begin valid8_i = 1'b1; a8_i = a[7:0]; b8_i = b[7:0]; borrow8_i = bin; end
    check("ready_before_accept", 32'(cur_ready(wide)), 32'd1);
    @(posedge clk); #1;
    valid8_i = 1'b0; valid32_i = 1'b0;
    a32_i = $urandom; b32_i = $urandom; a8_i = 8'($urandom); b8_i = 8'($urandom);
    borrow8_i = 1'($urandom); borrow32_i = 1'($urandom);
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (cur_valid(wide) || lat >= 64) break;
      set_ready(wide, 1'($urandom));
    end
    set_ready(wide, 1'b0);
    diff = cur_diff(wide);
    bo   = cur_bo(wide);
    ov   = cur_ov(wide);
    z    = cur_z(wide);
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        if (wide) begin valid32_i = ~valid32_i; a32_i = $urandom; end
        else begin valid8_i = ~valid8_i; a8_i = 8'($urandom); end
      end
      @(posedge clk); #1;
      check("hold_valid", 32'(cur_valid(wide)), 32'd1);
      check("hold_ready", 32'(cur_ready(wide)), 32'd0);
      check("hold_diff", cur_diff(wide), diff);
      check("hold_flags", {29'h0, cur_bo(wide), cur_ov(wide), cur_z(wide)}, {29'h0, bo, ov, z});
    end
    valid8_i = 1'b0; valid32_i = 1'b0;
    set_ready(wide, 1'b1);
    @(posedge clk); #1;
    set_ready(wide, 1'b0);
    check("ready_after_done", 32'(cur_ready(wide)), 32'd1);
    check("valid_after_done", 32'(cur_valid(wide)), 32'd0);
  endtask

  task automatic checkOutput(input string name, input bit wide, input logic [31:0] a,
                             input logic [31:0] b, input logic bin, input int stall, input bit poke);
    logic [31:0] d, ed;
    logic bo, ov, z, ebo, eov, ez;
    int lat;
    ref_model(wide ? 32 : 8, a, b, bin, ed, ebo, eov, ez);
    applyStimulus(wide, a, b, bin, stall, poke, d, bo, ov, z, lat);
    check({name, "_latency"}, 32'(lat), wide ? 32'd8 : 32'd2);
    check({name, "_diff"}, d, ed);
    check({name, "_borrow"}, 32'(bo), 32'(ebo));
    check({name, "_overflow"}, 32'(ov), 32'(eov));
    check({name, "_zero"}, 32'(z), 32'(ez));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] d;
    logic bo, ov, z;
    int lat;
    bit  saw_valid;

    vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0, z: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0, z: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1, z: 1'b0};
    vecs[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0, ov: 1'b0, z: 1'b1};

    rst_n = 1'b0;
    valid8_i = 1'b0; ready8_i = 1'b0; a8_i = '0; b8_i = '0; borrow8_i = 1'b0;
    valid32_i = 1'b0; ready32_i = 1'b0; a32_i = '0; b32_i = '0; borrow32_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready8", 32'(ready8_o), 32'd1);
    check("reset_valid8", 32'(valid8_o), 32'd0);
    check("reset_ready32", 32'(ready32_o), 32'd1);
    check("reset_valid32", 32'(valid32_o), 32'd0);
    check("reset_diff32", diff32_o, 32'h0);
    check("reset_flags32", {29'h0, borrow32_o, overflow32_o, zero32_o}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed 8-bit vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, {24'h0, vecs[i].a}, {24'h0, vecs[i].b}, vecs[i].bin, 0, 1'b0,
                    d, bo, ov, z, lat);
      check("vec_latency", 32'(lat), 32'd2);
      check("vec_diff", d, {24'h0, vecs[i].d});
      check("vec_borrow", 32'(bo), 32'(vecs[i].bo));
      check("vec_overflow", 32'(ov), 32'(vecs[i].ov));
      check("vec_zero", 32'(z), 32'(vecs[i].z));
    end

    $display("[TB] 32-bit op with consumer stall and ignored valid pulses");
    applyStimulus(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 5, 1'b1, d, bo, ov, z, lat);
    check("stall_latency", 32'(lat), 32'd8);
    check("stall_diff", d, 32'h0246_8ACF);
    check("stall_flags", {29'h0, bo, ov, z}, 32'h0);
    @(posedge clk); #1;
    check("stall_no_spurious_accept", 32'(ready32_o), 32'd1);

    $display("[TB] reset during third busy cycle");
    valid32_i = 1'b1; a32_i = 32'hDEAD_BEEF; b32_i = 32'h0123_4567; borrow32_i = 1'b0;
    @(posedge clk); #1;
    valid32_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 32'(ready32_o), 32'd1);
    check("abort_valid", 32'(valid32_o), 32'd0);
    check("abort_diff", diff32_o, 32'h0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (valid32_o) saw_valid = 1'b1;
    end
    check("abort_never_valid", 32'(saw_valid), 32'd0);
    checkOutput("after_abort", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
      checkOutput("rand32", 1'b1, ra, rb, 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = {24'h0, 8'($urandom)};
      rb = ($urandom_range(0, 7) == 0) ? ra : {24'h0, 8'($urandom)};
      checkOutput("rand8", 1'b0, ra, rb, 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
